// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and the IOP.
// Each winning request is latched, optionally stretched by WAIT_STATES cycles and acknowledged for one cycle.
module memory_arbiter #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_write,
    input  logic [15:31] cpu_address,
    input  logic [0:31]  cpu_data_in,
    output logic         cpu_ack,
    output logic [0:31]  cpu_data_out,
    input  logic         iop_req,
    input  logic         iop_write,
    input  logic [15:31] iop_address,
    input  logic [0:31]  iop_data_in,
    output logic         iop_ack,
    output logic [0:31]  iop_data_out,
    output logic [15:31] mem_address,
    output logic         mem_write_en,
    output logic [0:31]  mem_data_out,
    input  logic [0:31]  mem_data_in,
    output logic         owner
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IOP = 1'b1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic               wr_q, wr_d;
    logic [15:31]       mem_address_q, mem_address_d;
    logic [0:31]        mem_data_q, mem_data_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               iop_ack_q, iop_ack_d;
    logic [0:31]        cpu_data_q, cpu_data_d;
    logic [0:31]        iop_data_q, iop_data_d;

    logic cpu_elig, iop_elig, grant, grant_port;

    // A port whose ack is high is being served and does not compete.
    assign cpu_elig = cpu_req & ~cpu_ack_q;
    assign iop_elig = iop_req & ~iop_ack_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        owner_d       = owner_q;
        wr_d          = wr_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        cpu_ack_d     = 1'b0;
        iop_ack_d     = 1'b0;
        cpu_data_d    = cpu_data_q;
        iop_data_d    = iop_data_q;
        grant         = 1'b0;
        grant_port    = owner_q;

        case (state_q)
            IDLE: begin
                if (cpu_elig || iop_elig) begin
                    grant      = 1'b1;
                    grant_port = (cpu_elig && iop_elig) ? ~last_q : iop_elig;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Completion edge: return data, pulse ack, hand over to the other port if it waits.
                    if (owner_q == PORT_IOP) begin
                        iop_ack_d = 1'b1;
                        if (!wr_q) iop_data_d = mem_data_in;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!wr_q) cpu_data_d = mem_data_in;
                    end
                    last_d  = owner_q;
                    state_d = IDLE;
                    if ((owner_q == PORT_IOP) ? cpu_elig : iop_elig) begin
                        grant      = 1'b1;
                        grant_port = ~owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            state_d       = ACCESS;
            owner_d       = grant_port;
            cnt_d         = WAIT_INIT;
            wr_d          = grant_port ? iop_write   : cpu_write;
            mem_address_d = grant_port ? iop_address : cpu_address;
            mem_data_d    = grant_port ? iop_data_in : cpu_data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_q        <= PORT_IOP;
            owner_q       <= PORT_CPU;
            wr_q          <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            cpu_ack_q     <= 1'b0;
            iop_ack_q     <= 1'b0;
            cpu_data_q    <= '0;
            iop_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            wr_q          <= wr_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            cpu_ack_q     <= cpu_ack_d;
            iop_ack_q     <= iop_ack_d;
            cpu_data_q    <= cpu_data_d;
            iop_data_q    <= iop_data_d;
        end
    end

    // Decoded from flops only, so it drops as soon as reset clears the state.
    assign mem_write_en = (state_q == ACCESS) && (cnt_q == '0) && wr_q;

    assign cpu_ack      = cpu_ack_q;
    assign iop_ack      = iop_ack_q;
    assign cpu_data_out = cpu_data_q;
    assign iop_data_out = iop_data_q;
    assign mem_address  = mem_address_q;
    assign mem_data_out = mem_data_q;
    assign owner        = owner_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: two instances (0 and 3 wait states) checked against a transaction-level model.
module tb_memory_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]    rst_v = 2'b00;
    logic          act   = 1'b0;
    logic          c_req = 1'b0, c_wr = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_din  = '0;
    logic          i_req = 1'b0, i_wr = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_din  = '0;

    logic [1:0]    cpu_ack_v, iop_ack_v, owner_v, mem_we_v;
    logic [DW-1:0] cpu_dout_v [2];
    logic [DW-1:0] iop_dout_v [2];
    logic [DW-1:0] mem_dout_v [2];
    logic [AW-1:0] mem_addr_v [2];
    logic [DW-1:0] mem_rdata;

    memory_arbiter #(.WAIT_STATES(0)) u_dut_w0 (
        .clock(clock), .reset(rst_v[0]),
        .cpu_req(c_req), .cpu_write(c_wr), .cpu_address(c_addr), .cpu_data_in(c_din),
        .cpu_ack(cpu_ack_v[0]), .cpu_data_out(cpu_dout_v[0]),
        .iop_req(i_req), .iop_write(i_wr), .iop_address(i_addr), .iop_data_in(i_din),
        .iop_ack(iop_ack_v[0]), .iop_data_out(iop_dout_v[0]),
        .mem_address(mem_addr_v[0]), .mem_write_en(mem_we_v[0]),
        .mem_data_out(mem_dout_v[0]), .mem_data_in(mem_rdata), .owner(owner_v[0])
    );

    memory_arbiter #(.WAIT_STATES(3)) u_dut_w3 (
        .clock(clock), .reset(rst_v[1]),
        .cpu_req(c_req), .cpu_write(c_wr), .cpu_address(c_addr), .cpu_data_in(c_din),
        .cpu_ack(cpu_ack_v[1]), .cpu_data_out(cpu_dout_v[1]),
        .iop_req(i_req), .iop_write(i_wr), .iop_address(i_addr), .iop_data_in(i_din),
        .iop_ack(iop_ack_v[1]), .iop_data_out(iop_dout_v[1]),
        .mem_address(mem_addr_v[1]), .mem_write_en(mem_we_v[1]),
        .mem_data_out(mem_dout_v[1]), .mem_data_in(mem_rdata), .owner(owner_v[1])
    );

    // View of whichever instance is active; the other is held in reset.
    logic          cpu_ack, iop_ack, owner, mem_we, rst_act;
    logic [DW-1:0] cpu_dout, iop_dout, mem_dout;
    logic [AW-1:0] mem_addr;
    assign cpu_ack  = cpu_ack_v[act];
    assign iop_ack  = iop_ack_v[act];
    assign owner    = owner_v[act];
    assign mem_we   = mem_we_v[act];
    assign rst_act  = rst_v[act];
    assign cpu_dout = cpu_dout_v[act];
    assign iop_dout = iop_dout_v[act];
    assign mem_dout = mem_dout_v[act];
    assign mem_addr = mem_addr_v[act];

    logic [DW-1:0] ram [256] = '{default: '0};
    assign mem_rdata = ram[mem_addr[7:0]];
    always @(posedge clock) if (mem_we) ram[mem_addr[7:0]] <= mem_dout;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endfunction

    // Reference model: one in-flight transaction finishing at an absolute edge number.
    int            cyc = 0;
    bit            m_busy, m_wr, m_owner, m_last;
    bit [1:0]      m_ack;
    int            m_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_dout [2];
    logic [DW-1:0] shadow [256] = '{default: '0};

    function automatic void model_reset();
        m_busy = 1'b0; m_wr = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_ack = 2'b00;
        m_addr = '0; m_data = '0; m_dout[0] = '0; m_dout[1] = '0;
    endfunction

    function automatic void model_grant(bit p);
        m_busy  = 1'b1;
        m_owner = p;
        m_wr    = p ? i_wr : c_wr;
        m_addr  = p ? i_addr : c_addr;
        m_data  = p ? i_din : c_din;
        m_done  = cyc + (act ? 3 : 0) + 1;
    endfunction

    function automatic void model_step();
        bit [1:0] new_ack = 2'b00;
        bit       el_c, el_i;
        cyc++;
        el_c = c_req && !m_ack[0];
        el_i = i_req && !m_ack[1];
        if (m_busy && cyc == m_done) begin
            if (m_wr) shadow[m_addr[7:0]] = m_data;
            else      m_dout[m_owner] = shadow[m_addr[7:0]];
            new_ack[m_owner] = 1'b1;
            m_last = m_owner;
            m_busy = 1'b0;
            if (m_owner ? el_c : el_i) model_grant(!m_owner);
        end else if (!m_busy) begin
            if (el_c && el_i) model_grant(!m_last);
            else if (el_c)    model_grant(1'b0);
            else if (el_i)    model_grant(1'b1);
        end
        m_ack = new_ack;
    endfunction

    always @(posedge clock) begin
        if (!rst_act) model_reset();
        else          model_step();
    end

    always @(negedge clock) begin
        if (!rst_act) model_reset();
        chk("owner",        DW'(owner),   DW'(m_owner));
        chk("cpu_ack",      DW'(cpu_ack), DW'(m_ack[0]));
        chk("iop_ack",      DW'(iop_ack), DW'(m_ack[1]));
        chk("cpu_data_out", cpu_dout,     m_dout[0]);
        chk("iop_data_out", iop_dout,     m_dout[1]);
        chk("mem_address",  DW'(mem_addr), DW'(m_addr));
        chk("mem_data_out", mem_dout,     m_data);
        chk("mem_write_en", DW'(mem_we),  DW'(m_busy && m_wr && (cyc + 1 == m_done)));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Requesters: drop req on ack, otherwise raise a new random request with probability prob%.
    task automatic drive(int prob);
        if (cpu_ack) c_req = 1'b0;
        else if (!c_req && int'($urandom_range(0, 99)) < prob) begin
            c_req = 1'b1; c_wr = 1'($urandom_range(0, 1));
            c_addr = AW'(32'h40 + $urandom_range(0, 63)); c_din = $urandom;
        end
        if (iop_ack) i_req = 1'b0;
        else if (!i_req && int'($urandom_range(0, 99)) < prob) begin
            i_req = 1'b1; i_wr = 1'($urandom_range(0, 1));
            i_addr = AW'(32'h40 + $urandom_range(0, 63)); i_din = $urandom;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            tick();
            drive(0);
            if (!c_req && !i_req) break;
        end
        chk("drain_done", DW'({c_req, i_req}), '0);
        c_req = 1'b0;
        i_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[$];
        int repeats;
        logic prev_c, prev_i;

        // Reset held with random inputs
        for (int k = 0; k < 4; k++) begin
            c_req = 1'($urandom_range(0, 1)); i_req = 1'($urandom_range(0, 1));
            c_wr = 1'($urandom_range(0, 1)); i_wr = 1'($urandom_range(0, 1));
            c_addr = AW'($urandom); i_addr = AW'($urandom); c_din = $urandom; i_din = $urandom;
            tick();
        end
        chk("rst_owner", DW'(owner), '0);
        chk("rst_mem_we", DW'(mem_we), '0);
        chk("rst_mem_addr", DW'(mem_addr), '0);
        c_req = 1'b0; i_req = 1'b0;
        rst_v[0] = 1'b1;
        tick();

        // CPU write then read back, no wait states
        c_req = 1'b1; c_wr = 1'b1; c_addr = AW'(32'h10); c_din = 32'h12345678;
        tick();
        chk("wr_owner", DW'(owner), '0);
        chk("wr_mem_we", DW'(mem_we), 1);
        chk("wr_mem_addr", DW'(mem_addr), 32'h10);
        tick();
        chk("wr_ack", DW'(cpu_ack), 1);
        chk("wr_we_low", DW'(mem_we), '0);
        c_req = 1'b0;
        tick();
        chk("wr_ack_low", DW'(cpu_ack), '0);
        c_req = 1'b1; c_wr = 1'b0; c_addr = AW'(32'h10);
        tick();
        tick();
        chk("rd_ack", DW'(cpu_ack), 1);
        chk("rd_data", cpu_dout, 32'h12345678);
        c_req = 1'b0;
        tick();

        // Tie right after reset: CPU first, IOP back-to-back
        rst_v[0] = 1'b0;
        tick();
        rst_v[0] = 1'b1;
        tick();
        c_req = 1'b1; c_wr = 1'b0; c_addr = AW'(32'h10);
        i_req = 1'b1; i_wr = 1'b1; i_addr = AW'(32'h11); i_din = 32'hA5A5_0001;
        tick();
        chk("tie_owner_e0", DW'(owner), '0);
        tick();
        chk("tie_cpu_ack", DW'(cpu_ack), 1);
        chk("tie_owner_e1", DW'(owner), 1);
        c_req = 1'b0;
        tick();
        chk("tie_iop_ack", DW'(iop_ack), 1);
        chk("tie_cpu_ack_low", DW'(cpu_ack), '0);
        i_req = 1'b0;
        tick();

        // Fairness under continuous demand
        repeats = 0; prev_c = 1'b0; prev_i = 1'b0;
        for (int k = 0; k < 40 && seq.size() < 4; k++) begin
            drive(100);
            tick();
            if (cpu_ack) seq.push_back(0);
            if (iop_ack) seq.push_back(1);
            if ((cpu_ack && prev_c) || (iop_ack && prev_i)) repeats++;
            prev_c = cpu_ack; prev_i = iop_ack;
        end
        chk("fair_count", DW'(seq.size()), 4);
        for (int k = 0; k < seq.size(); k++) chk("fair_order", DW'(seq[k]), DW'(k % 2));
        chk("fair_no_repeat", DW'(repeats), '0);
        drain();

        repeat (300) begin
            drive(40);
            tick();
        end
        drain();

        // Switch to the three-wait-state instance
        rst_v = 2'b00;
        act = 1'b1;
        tick();
        tick();
        rst_v[1] = 1'b1;
        tick();

        i_req = 1'b1; i_wr = 1'b1; i_addr = AW'(32'h30); i_din = 32'hCAFEF00D;
        for (int e = 0; e <= 5; e++) begin
            tick();
            chk("w3_we", DW'(mem_we), DW'(e == 3));
            chk("w3_iop_ack", DW'(iop_ack), DW'(e == 4));
            if (iop_ack) i_req = 1'b0;
        end
        i_req = 1'b1; i_wr = 1'b0; i_addr = AW'(32'h30);
        for (int e = 0; e <= 4; e++) begin
            tick();
            chk("w3_rd_ack", DW'(iop_ack), DW'(e == 4));
            if (e == 4) chk("w3_rd_data", iop_dout, 32'hCAFEF00D);
            if (iop_ack) i_req = 1'b0;
        end
        tick();

        // Reset during the second access cycle of a CPU write
        c_req = 1'b1; c_wr = 1'b1; c_addr = AW'(32'h20); c_din = 32'hDEADBEEF;
        tick();
        tick();
        rst_v[1] = 1'b0;
        #1;
        chk("abort_we", DW'(mem_we), '0);
        chk("abort_ack", DW'(cpu_ack), '0);
        c_req = 1'b0;
        tick();
        tick();
        chk("abort_ack_held", DW'(cpu_ack), '0);
        rst_v[1] = 1'b1;
        tick();
        c_req = 1'b1; c_wr = 1'b0; c_addr = AW'(32'h20);
        for (int e = 0; e <= 4; e++) begin
            tick();
            chk("abort_rd_ack", DW'(cpu_ack), DW'(e == 4));
            if (e == 4) chk("abort_rd_data", cpu_dout, 32'h0);
            if (cpu_ack) c_req = 1'b0;
        end
        tick();

        repeat (400) begin
            drive(40);
            tick();
        end
        drain();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single test memory port between the CPU and a second requester (IOP/DMA) so both can reach the same `ram_cells` array. It sits between the two requesters and the memory module. It registers each winning request, optionally stretches the access by a fixed number of wait states, and returns read data with a one-cycle acknowledge. Arbitration is round-robin, so continuous demand from one side cannot starve the other.

## Interface

- `WAIT_STATES`, default 0: extra cycles inserted before each access completes (0..15).
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_write`  in  1  1 = write, 0 = read.
- `cpu_address`  in  [15:31]  word address.
- `cpu_data_in`  in  [0:31]  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_data_out`  out  [0:31]  read data; valid while `cpu_ack` = 1, held afterwards.
- `iop_req`, `iop_write`, `iop_address`, `iop_data_in`, `iop_ack`, `iop_data_out`: same as the CPU port, for the IOP.
- `mem_address`  out  [15:31]  to memory `address`.
- `mem_write_en`  out  1  to memory `write_en`.
- `mem_data_out`  out  [0:31]  to memory `data_in`.
- `mem_data_in`  in  [0:31]  from memory `data_out`; combinational read.
- `owner`  out  1  0 = CPU, 1 = IOP; the requester latched for the current or last access.

## Operation

- FSM states: IDLE and ACCESS. A 4-bit wait counter and a `last` flag (last port served) support it.
- **Eligibility.** A port is eligible when its `req` = 1 and its `ack` is not currently high. A port whose ack is high is being served and must drop `req` in that cycle.
- **Arbitration.**
  - If only one port is eligible, it wins.
  - If both are eligible, the port with `last` ≠ port wins.
  - Arbitration runs in IDLE and again at the completion edge of ACCESS. At the completion edge only the other port is considered.
- **On grant:**
  - latch write flag, address and data into `mem_address`/`mem_data_out`;
  - set `owner` to the winner;
  - load the counter with `WAIT_STATES`;
  - enter ACCESS.
- **ACCESS:**
  - If counter ≠ 0, decrement.
  - If counter = 0, this is the completion edge:
    - the memory performs the write (when the write flag is set);
    - `mem_data_in` is captured into the owner's `data_out`, for reads only; writes leave `data_out` unchanged;
    - the owner's ack is set for exactly one cycle;
    - `last` is set to the owner;
    - the FSM re-arbitrates: it goes to ACCESS for the other port if that port is eligible, otherwise to IDLE.
- **Write enable.** `mem_write_en` = (state == ACCESS) & (counter == 0) & latched write. It is decoded from registers only, so it is glitch-free and high for exactly one cycle per write.
- `mem_address` and `mem_data_out` hold their last values while IDLE.
- **Reset values** (asynchronous, while `reset` = 0):
  - state IDLE, counter 0, `last` = IOP (so the CPU wins the first tie);
  - `owner` 0, both acks 0, both `data_out` 0;
  - `mem_address` 0, `mem_data_out` 0, `mem_write_en` 0.
- **Reset mid-access:** the access is aborted, no write occurs, no ack is issued, and `mem_write_en` falls immediately.

## Timing

- Edge E0 samples an eligible request in IDLE. Completion is at edge E(WAIT_STATES+1). Ack is high from E(W+1) to E(W+2).
- For a read, data is valid on `data_out` in the same cycle as ack.
- **Back-to-back.** The second port's ACCESS starts at the first port's completion edge, so there are no idle cycles between the two. With `WAIT_STATES` = 0, one access completes every cycle, alternating between ports.
- **Same-port re-request.** A port that re-asserts `req` right after its ack is sampled no earlier than the edge ending its ack cycle. Minimum same-port spacing is therefore W+2 cycles.
- Requesters must hold `write`/`address`/`data_in` stable only until the grant edge; they are latched there.

## Test plan

1. **Reset.** Hold `reset` = 0 with random inputs → all outputs are 0 and `mem_write_en` = 0. Release, then assert only `cpu_req` → `owner` = 0 at the grant.
2. **CPU write then read, W = 0.**
   - Write 0x12345678 to address 0x00010 → `mem_write_en` is high for one cycle with `mem_address` = 0x00010; `cpu_ack` is high E1–E2.
   - Read back 0x00010 → `cpu_data_out` = 0x12345678 while `cpu_ack` is high.
3. **Tie after reset, W = 0.** Raise both requests at the same edge → CPU is served first (`cpu_ack` E1–E2) and IOP next (`iop_ack` E2–E3, `owner` = 1). There are no idle cycles between them.
4. **Fairness.** Both ports request continuously for 4 accesses → ack order is CPU, IOP, CPU, IOP. Neither ack ever appears in two consecutive cycles.
5. **Wait states, W = 3.**
   - IOP write sampled at E0 → `mem_write_en` is high only during E3–E4; `iop_ack` is high E4–E5.
   - An IOP read issued afterwards completes at the 4th edge after its sample.
6. **Reset mid-access, W = 3.** Pull `reset` low during the second ACCESS cycle of a CPU write to 0x00020 (old value 0) → no ack is issued, and a subsequent read of 0x00020 returns 0x00000000.
